// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester and memory-side signal bundle for data_mem_arbiter
interface data_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  io_req;
    logic                  io_we;
    logic [ADDR_WIDTH-1:0] io_addr;
    logic [DATA_WIDTH-1:0] io_wdata;
    logic                  io_ack;
    logic [DATA_WIDTH-1:0] io_rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  grant_io;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  io_req, io_we, io_addr, io_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, io_ack, io_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, grant_io
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output io_req, io_we, io_addr, io_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, io_ack, io_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, grant_io
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/IO sharing of the single-port data RAM, round-robin or
// CPU-priority with IO starvation guard when ARB_CPU_PRIORITY_EN is defined
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WAIT   = 4
) (
    input logic               clk,
    input logic               reset,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    if (MAX_WAIT < 1) begin : g_max_wait_check
        $error("MAX_WAIT must be at least 1");
    end

    state_t                state_q, state_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  rd_q, rd_d;
    logic                  grant_io_q, grant_io_d;
    logic                  last_grant_q, last_grant_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  io_ack_q, io_ack_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] io_rdata_q, io_rdata_d;
    logic                  any_req;
    logic                  capture;
    logic                  pick_io;
    logic                  sel_we;

    assign any_req = bus.cpu_req | bus.io_req;
    assign sel_we  = pick_io ? bus.io_we : bus.cpu_we;

`ifdef ARB_CPU_PRIORITY_EN
    localparam int                  WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              both_req;

    assign both_req = bus.cpu_req & bus.io_req;
    // CPU wins ties until IO has lost MAX_WAIT of them in a row
    assign pick_io  = bus.io_req & (~bus.cpu_req | (wait_q == WAIT_LIMIT));

    always_comb begin
        wait_d = wait_q;
        if (capture) begin
            if (pick_io) begin
                wait_d = '0;
            end else if (both_req && (wait_q != WAIT_LIMIT)) begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign pick_io = bus.io_req & (~bus.cpu_req | ~last_grant_q);
`endif

    always_comb begin
        state_d      = state_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rd_d         = rd_q;
        grant_io_d   = grant_io_q;
        last_grant_d = last_grant_q;
        cpu_ack_d    = 1'b0;
        io_ack_d     = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        io_rdata_d   = io_rdata_q;
        capture      = 1'b0;

        case (state_q)
            IDLE: begin
                capture = any_req;
            end
            ISSUE: begin
                state_d   = RESP;
                cpu_ack_d = ~grant_io_q;
                io_ack_d  = grant_io_q;
            end
            RESP: begin
                state_d = IDLE;
                capture = any_req;
                if (rd_q) begin
                    if (grant_io_q) begin
                        io_rdata_d = bus.mem_rdata;
                    end else begin
                        cpu_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            state_d      = ISSUE;
            mem_en_d     = 1'b1;
            mem_we_d     = sel_we;
            mem_addr_d   = pick_io ? bus.io_addr : bus.cpu_addr;
            mem_wdata_d  = pick_io ? bus.io_wdata : bus.cpu_wdata;
            rd_d         = ~sel_we;
            grant_io_d   = pick_io;
            last_grant_d = pick_io;
        end
    end

    // last_grant starts at IO so the CPU takes the first tie after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_q         <= 1'b0;
            grant_io_q   <= 1'b0;
            last_grant_q <= 1'b1;
            cpu_ack_q    <= 1'b0;
            io_ack_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            io_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_q         <= rd_d;
            grant_io_q   <= grant_io_d;
            last_grant_q <= last_grant_d;
            cpu_ack_q    <= cpu_ack_d;
            io_ack_q     <= io_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            io_rdata_q   <= io_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.grant_io  = grant_io_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.io_ack    = io_ack_q;
    // RAM data only arrives during RESP, so the ack cycle forwards it while it is registered
    assign bus.cpu_rdata = (state_q == RESP && rd_q && !grant_io_q) ? bus.mem_rdata : cpu_rdata_q;
    assign bus.io_rdata  = (state_q == RESP && rd_q &&  grant_io_q) ? bus.mem_rdata : io_rdata_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int MW = 4;

    typedef struct packed {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          cack;
        logic          iack;
        logic          gio;
        logic [DW-1:0] crd;
        logic [DW-1:0] ird;
    } exp_t;

    typedef struct packed {
        logic          rst_n;
        logic          creq;
        logic          cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          ireq;
        logic          iwe;
        logic [AW-1:0] iaddr;
        logic [DW-1:0] iwd;
        exp_t          e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    data_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous RAM; unwritten words read back their own address (port values)
    logic [DW-1:0]       ram [0:(1<<AW)-1];
    bit   [(1<<AW)-1:0]  ram_vld;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr]     <= bus.mem_wdata;
                ram_vld[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= ram_vld[bus.mem_addr] ? ram[bus.mem_addr] : DW'(bus.mem_addr);
            end
        end
    end

    logic [DW-1:0] sh [int];

    function automatic logic [DW-1:0] sh_rd(input int a);
        return sh.exists(a) ? sh[a] : DW'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, " mem_en"},    32'(bus.mem_en),    32'(e.en));
        chk({tag, " mem_we"},    32'(bus.mem_we),    32'(e.we));
        chk({tag, " mem_addr"},  32'(bus.mem_addr),  32'(e.addr));
        chk({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'(e.wd));
        chk({tag, " cpu_ack"},   32'(bus.cpu_ack),   32'(e.cack));
        chk({tag, " io_ack"},    32'(bus.io_ack),    32'(e.iack));
        chk({tag, " grant_io"},  32'(bus.grant_io),  32'(e.gio));
        chk({tag, " cpu_rdata"}, 32'(bus.cpu_rdata), 32'(e.crd));
        chk({tag, " io_rdata"},  32'(bus.io_rdata),  32'(e.ird));
        chk({tag, " one_ack"},   32'(bus.cpu_ack & bus.io_ack), 32'd0);
    endtask

    function automatic vec_t mkv(input bit r, input bit cq, input bit cw, input int ca,
                                 input logic [31:0] cd, input bit iq, input bit iw, input int ia,
                                 input logic [31:0] id, input bit en, input bit we, input int a,
                                 input logic [31:0] wd, input bit cak, input bit iak, input bit g,
                                 input logic [31:0] crd, input logic [31:0] ird);
        vec_t v;
        v.rst_n = r;  v.creq = cq; v.cwe = cw; v.caddr = AW'(ca); v.cwd = cd;
        v.ireq  = iq; v.iwe  = iw; v.iaddr = AW'(ia); v.iwd = id;
        v.e.en = en; v.e.we = we; v.e.addr = AW'(a); v.e.wd = wd;
        v.e.cack = cak; v.e.iack = iak; v.e.gio = g; v.e.crd = crd; v.e.ird = ird;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_n         = v.rst_n;
        bus.cpu_req   = v.creq;
        bus.cpu_we    = v.cwe;
        bus.cpu_addr  = v.caddr;
        bus.cpu_wdata = v.cwd;
        bus.io_req    = v.ireq;
        bus.io_we     = v.iwe;
        bus.io_addr   = v.iaddr;
        bus.io_wdata  = v.iwd;
    endtask

    function automatic bit contend_is_io(input int n);
`ifdef ARB_CPU_PRIORITY_EN
        return (n % (MW + 1)) == MW;
`else
        return (n % 2) == 1;
`endif
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [16];
        exp_t e;
        int   n_ack, last_c;
        bit   c_pend, i_pend, c_we, i_we, resp_pend, resp_io, resp_read, win, last_io;
        logic [AW-1:0] c_addr, i_addr;
        logic [DW-1:0] c_wd, i_wd, resp_data;
        int   waits;

        drive(mkv(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
        //          rst cq cw ca cd            iq iw ia id        en we a wd            ca ia g  crd           ird
        tbl[0]  = mkv(0, 1,1,5,32'hDEADBEEF, 1,1,7,32'h1234, 0,0,0,0,             0,0,0, 0,            0);
        tbl[1]  = mkv(0, 1,1,5,32'hDEADBEEF, 1,1,7,32'h1234, 0,0,0,0,             0,0,0, 0,            0);
        tbl[2]  = mkv(1, 1,1,5,32'hDEADBEEF, 1,1,7,32'h1234, 1,1,5,32'hDEADBEEF,  0,0,0, 0,            0);
        tbl[3]  = mkv(1, 1,1,5,32'hDEADBEEF, 1,1,7,32'h1234, 0,0,5,32'hDEADBEEF,  1,0,0, 0,            0);
        tbl[4]  = mkv(1, 0,0,0,0,            1,1,7,32'h1234, 1,1,7,32'h1234,      0,0,1, 0,            0);
        tbl[5]  = mkv(1, 0,0,0,0,            1,1,7,32'h1234, 0,0,7,32'h1234,      0,1,1, 0,            0);
        tbl[6]  = mkv(1, 1,0,5,0,            0,0,0,0,        1,0,5,0,             0,0,0, 0,            0);
        tbl[7]  = mkv(1, 1,0,5,0,            0,0,0,0,        0,0,5,0,             1,0,0, 32'hDEADBEEF, 0);
        tbl[8]  = mkv(1, 0,0,0,0,            0,0,0,0,        0,0,5,0,             0,0,0, 32'hDEADBEEF, 0);
        tbl[9]  = mkv(1, 0,0,0,0,            1,0,3,0,        1,0,3,0,             0,0,1, 32'hDEADBEEF, 0);
        tbl[10] = mkv(1, 0,0,0,0,            1,0,3,0,        0,0,3,0,             0,1,1, 32'hDEADBEEF, 3);
        tbl[11] = mkv(1, 1,0,7,0,            0,0,0,0,        1,0,7,0,             0,0,0, 32'hDEADBEEF, 3);
        tbl[12] = mkv(1, 1,0,7,0,            0,0,0,0,        0,0,7,0,             1,0,0, 32'h1234,     3);
        tbl[13] = mkv(1, 1,0,3,0,            0,0,0,0,        1,0,3,0,             0,0,0, 32'h1234,     3);
        tbl[14] = mkv(1, 1,0,3,0,            0,0,0,0,        0,0,3,0,             1,0,0, 3,            3);
        tbl[15] = mkv(1, 0,0,0,0,            0,0,0,0,        0,0,3,0,             0,0,0, 3,            3);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].e);
        end

        // Reset asserted in the middle of ISSUE abandons the write, then it is retried
        @(negedge clk);
        drive(mkv(1, 1,1,9,32'hA5A5A5A5, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
        @(posedge clk);
        #1;
        chk("rst_mid issue mem_en", 32'(bus.mem_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid mem_en drop", 32'(bus.mem_en), 32'd0);
        chk("rst_mid mem_we drop", 32'(bus.mem_we), 32'd0);
        chk("rst_mid mem_addr clr", 32'(bus.mem_addr), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid no cpu_ack", 32'(bus.cpu_ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid reissue mem_en", 32'(bus.mem_en), 32'd1);
        chk("rst_mid reissue addr", 32'(bus.mem_addr), 32'd9);
        @(posedge clk);
        #1;
        chk("rst_mid reissue cpu_ack", 32'(bus.cpu_ack), 32'd1);
        @(negedge clk);
        bus.cpu_req = 1'b0;

        // Both requesters held high from reset release
        @(negedge clk);
        rst_n = 1'b0;
        drive(mkv(0, 1,0,1,0, 1,0,2,0, 0,0,0,0, 0,0,0, 0,0));
        @(negedge clk);
        rst_n = 1'b1;
        n_ack  = 0;
        last_c = 0;
        for (int c = 0; c < 40 && n_ack < 10; c++) begin
            @(posedge clk);
            #1;
            chk("contend one_ack", 32'(bus.cpu_ack & bus.io_ack), 32'd0);
            if (bus.cpu_ack || bus.io_ack) begin
                chk($sformatf("contend grant%0d", n_ack), 32'(bus.io_ack), 32'(contend_is_io(n_ack)));
                if (bus.cpu_ack) chk("contend cpu_rdata", bus.cpu_rdata, 32'd1);
                if (bus.io_ack)  chk("contend io_rdata", bus.io_rdata, 32'd2);
                if (n_ack > 0) chk("contend spacing", 32'(c - last_c), 32'd2);
                last_c = c;
                n_ack++;
            end
        end
        chk("contend ack count", 32'(n_ack), 32'd10);

        // Randomized traffic against a transaction-level reference
        @(negedge clk);
        drive(mkv(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
        @(negedge clk);
        rst_n = 1'b1;
        e = '0;
        c_pend = 0; i_pend = 0; resp_pend = 0; last_io = 1; waits = 0;
        c_we = 0; i_we = 0; c_addr = '0; i_addr = '0; c_wd = '0; i_wd = '0;
        resp_io = 0; resp_read = 0; resp_data = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (!c_pend && $urandom_range(0, 2) != 0) begin
                c_pend = 1; c_we = 1'($urandom_range(0, 1));
                c_addr = AW'(16 + $urandom_range(0, 15)); c_wd = $urandom;
            end
            if (!i_pend && $urandom_range(0, 2) != 0) begin
                i_pend = 1; i_we = 1'($urandom_range(0, 1));
                i_addr = AW'(16 + $urandom_range(0, 15)); i_wd = $urandom;
            end
            bus.cpu_req = c_pend; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wd;
            bus.io_req  = i_pend; bus.io_we  = i_we; bus.io_addr  = i_addr; bus.io_wdata  = i_wd;

            e.en = 0; e.we = 0; e.cack = 0; e.iack = 0;
            if (resp_pend) begin
                resp_pend = 0;
                if (resp_io) begin
                    e.iack = 1; i_pend = 0;
                    if (resp_read) e.ird = resp_data;
                end else begin
                    e.cack = 1; c_pend = 0;
                    if (resp_read) e.crd = resp_data;
                end
            end else if (c_pend || i_pend) begin
                if (c_pend && i_pend) begin
`ifdef ARB_CPU_PRIORITY_EN
                    win = (waits == MW);
                    if (!win) waits = waits + 1;
`else
                    win = !last_io;
`endif
                end else begin
                    win = i_pend;
                end
                if (win) waits = 0;
                last_io   = win;
                e.en      = 1;
                e.we      = win ? i_we : c_we;
                e.addr    = win ? i_addr : c_addr;
                e.wd      = win ? i_wd : c_wd;
                e.gio     = win;
                resp_pend = 1;
                resp_io   = win;
                resp_read = !e.we;
                if (e.we) sh[int'(e.addr)] = e.wd;
                else      resp_data = sh_rd(int'(e.addr));
            end
            @(posedge clk);
            #1;
            check_all("rnd", e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
